// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the exec stage. A word array sits behind a single-entry store
//   buffer. Stores are captured in the buffer and written to the array later. A load returns
//   its extended result one cycle after it is accepted.
//
//   Optional feature: define DMEM_STORE_FORWARD_EN to merge buffered store bytes into a load of
//   the same word. Without the macro, such a load stalls for one cycle while the buffer drains.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     request present this cycle
//   req_write     1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     store data, low lanes
//   req_size      00 byte, 01 half, 10/11 word
//   req_unsigned  zero-extend load result
//   stall         request not accepted this cycle; requester holds req_*
//   rdata         registered, extended load result
//   rdata_valid   one-cycle pulse qualifying rdata
//   misalign      one-cycle pulse for an accepted misaligned request

module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    logic [31:0] mem [Words];

    logic                  sb_valid_q;
    logic [DEPTH_LOG2-1:0] sb_idx_q;
    logic [31:0]           sb_data_q;
    logic [3:0]            sb_mask_q;

    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        misalign_q;

    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            off;
    logic                  misaligned;
    logic                  conflict;
    logic                  load_req;
    logic                  load_acc;
    logic                  store_acc;
    logic                  drain;
    logic [31:0]           st_data;
    logic [3:0]            st_mask;
    logic [31:0]           rd_word;
    logic [31:0]           merged;
    logic [31:0]           shifted;
    logic [31:0]           ld_ext;

    // Upper address bits are intentionally ignored so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];

    assign idx        = req_addr[DEPTH_LOG2+1:2];
    assign off        = req_addr[1:0];
    assign misaligned = ((req_size == 2'b01) && off[0]) || (req_size[1] && (off != 2'b00));
    assign conflict   = sb_valid_q && (sb_idx_q == idx);
    assign load_req   = req_valid && !req_write && !misaligned;
    assign store_acc  = req_valid && req_write && !misaligned;

`ifdef DMEM_STORE_FORWARD_EN
    assign stall = 1'b0;
`else
    // Hold a load that hits the buffered word; the buffer drains during the stall cycle.
    assign stall = load_req && conflict && !rst;
`endif

    assign load_acc = load_req && !stall;
    // The array is only written when no load is accepted, so a load never races a write.
    assign drain    = sb_valid_q && !load_acc && !rst;

    // Replicating the data across lanes lets the mask alone pick the right bytes.
    always_comb begin
        st_data = req_wdata;
        st_mask = 4'b1111;
        unique case (req_size)
            2'b00: begin
                st_data = {4{req_wdata[7:0]}};
                st_mask = 4'b0001 << off;
            end
            2'b01: begin
                st_data = {2{req_wdata[15:0]}};
                st_mask = 4'b0011 << off;
            end
            default: begin
                st_data = req_wdata;
                st_mask = 4'b1111;
            end
        endcase
    end

    assign rd_word = mem[idx];

    always_comb begin
        merged = rd_word;
`ifdef DMEM_STORE_FORWARD_EN
        for (int i = 0; i < 4; i++) begin
            if (conflict && sb_mask_q[i]) begin
                merged[8*i +: 8] = sb_data_q[8*i +: 8];
            end
        end
`endif
        shifted = merged >> {off, 3'b000};
        unique case (req_size)
            2'b00:   ld_ext = {{24{!req_unsigned && shifted[7]}}, shifted[7:0]};
            2'b01:   ld_ext = {{16{!req_unsigned && shifted[15]}}, shifted[15:0]};
            default: ld_ext = merged;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            sb_valid_q    <= 1'b0;
            sb_idx_q      <= '0;
            sb_data_q     <= 32'h0;
            sb_mask_q     <= 4'h0;
        end else begin
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            if (req_valid && misaligned) begin
                misalign_q    <= 1'b1;
                rdata_q       <= 32'h0;
                rdata_valid_q <= !req_write;
            end else if (load_acc) begin
                rdata_q       <= ld_ext;
                rdata_valid_q <= 1'b1;
            end

            if (store_acc) begin
                sb_valid_q <= 1'b1;
                sb_idx_q   <= idx;
                sb_data_q  <= st_data;
                sb_mask_q  <= st_mask;
            end else if (drain) begin
                sb_valid_q <= 1'b0;
            end
        end
    end

    // Array contents are not reset.
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int i = 0; i < 4; i++) begin
                if (sb_mask_q[i]) begin
                    mem[sb_idx_q][8*i +: 8] <= sb_data_q[8*i +: 8];
                end
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;

    data_mem_responder #(.DEPTH_LOG2(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

`ifdef DMEM_STORE_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif
    localparam int AMask = (1 << 14) - 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte-addressed memory as seen by a program; stores are visible immediately.
    logic [7:0] mdl [int];
    // Word index of a store that has not yet had a cycle without an accepted load.
    bit pend_v = 1'b0;
    int pend_w = 0;

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b01) return a[0];
        if (sz >= 2'b10) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return (int'(a) & AMask) >> 2;
    endfunction

    function automatic logic [7:0] mbyte(input int a);
        int k;
        k = a & AMask;
        if (mdl.exists(k)) return mdl[k];
        return 8'h00;
    endfunction

    function automatic void mdl_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) mdl[(int'(a) + i) & AMask] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic u);
        int b;
        logic [15:0] h;
        b = int'(a);
        if (sz == 2'b00) begin
            if (u) return {24'h0, mbyte(b)};
            return {{24{mbyte(b)[7]}}, mbyte(b)};
        end
        if (sz == 2'b01) begin
            h = {mbyte(b + 1), mbyte(b)};
            if (u) return {16'h0, h};
            return {{16{h[15]}}, h};
        end
        return {mbyte(b + 3), mbyte(b + 2), mbyte(b + 1), mbyte(b)};
    endfunction

    // Presents one request at the falling edge and holds it while stall is high.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic u, output int stalls,
                         output logic [31:0] rd, output logic rv, output logic mi);
        logic s;
        stalls = 0;
        rd = 32'h0;
        rv = 1'b0;
        mi = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        req_wdata = d;
        req_size = sz;
        req_unsigned = u;
        for (int k = 0; k < 4; k++) begin
            #1;
            s = stall;
            @(posedge clk);
            #1;
            rd = rdata;
            rv = rdata_valid;
            mi = misalign;
            if (!s) break;
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom;
        req_write = $urandom_range(0, 1);
        @(posedge clk);
        #1;
        pend_v = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h100;
        req_wdata = 32'h0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({stall, rdata_valid, misalign, rdata} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got stall=%b rv=%b mis=%b rdata=%h, need all 0",
                     stall, rdata_valid, misalign, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        pend_v = 1'b0;
    endtask

    task automatic test_store_load();
        int st;
        logic [31:0] rd;
        logic rv, mi;
        issue(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, st, rd, rv, mi);
        mdl_store(32'h100, 32'hDEADBEEF, 2'b10);
        n_cmp++;
        if (st != 0 || rv !== 1'b0) begin
            n_bad++;
            $display("FAIL store_word: got stalls=%0d rv=%b, need 0 and 0", st, rv);
        end
        idle();
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, st, rd, rv, mi);
        n_cmp++;
        if (st != 0 || rv !== 1'b1 || rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL load_word: got stalls=%0d rv=%b rdata=%h, need 0 1 deadbeef",
                     st, rv, rd);
        end
        idle();
        n_cmp++;
        if (rdata_valid !== 1'b0 || misalign !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL idle_outputs: got rv=%b mis=%b rdata=%h, need 0 0 deadbeef",
                     rdata_valid, misalign, rdata);
        end
    endtask

    task automatic test_byte_forward();
        int st;
        logic [31:0] rd;
        logic rv, mi;
        issue(1'b1, 32'h203, 32'h00000080, 2'b00, 1'b0, st, rd, rv, mi);
        mdl_store(32'h203, 32'h80, 2'b00);
        issue(1'b0, 32'h203, 32'h0, 2'b00, 1'b0, st, rd, rv, mi);
        n_cmp++;
        if (st != (Fwd ? 0 : 1) || rv !== 1'b1 || rd !== 32'hFFFFFF80) begin
            n_bad++;
            $display("FAIL byte_conflict: got stalls=%0d rv=%b rdata=%h, need %0d 1 ffffff80",
                     st, rv, rd, Fwd ? 0 : 1);
        end
        idle();
    endtask

    task automatic test_misalign();
        int st;
        logic [31:0] rd;
        logic rv, mi;
        issue(1'b1, 32'h40, 32'hA5A55A5A, 2'b10, 1'b0, st, rd, rv, mi);
        mdl_store(32'h40, 32'hA5A55A5A, 2'b10);
        idle();
        issue(1'b0, 32'h41, 32'h0, 2'b01, 1'b1, st, rd, rv, mi);
        n_cmp++;
        if (st != 0 || mi !== 1'b1 || rv !== 1'b1 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL misalign_load: got stalls=%0d mis=%b rv=%b rdata=%h, need 0 1 1 0",
                     st, mi, rv, rd);
        end
        issue(1'b1, 32'h42, 32'h12345678, 2'b10, 1'b0, st, rd, rv, mi);
        n_cmp++;
        if (st != 0 || mi !== 1'b1 || rv !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_store: got stalls=%0d mis=%b rv=%b, need 0 1 0", st, mi, rv);
        end
        issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, st, rd, rv, mi);
        n_cmp++;
        if (mi !== 1'b0 || rv !== 1'b1 || rd !== mdl_load(32'h40, 2'b10, 1'b0)) begin
            n_bad++;
            $display("FAIL misalign_array: got mis=%b rv=%b rdata=%h, need 0 1 %h",
                     mi, rv, rd, mdl_load(32'h40, 2'b10, 1'b0));
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int st1, st2;
        logic [31:0] rd;
        logic rv, mi;
        issue(1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0, st1, rd, rv, mi);
        issue(1'b1, 32'h14, 32'h55667788, 2'b10, 1'b0, st2, rd, rv, mi);
        mdl_store(32'h10, 32'h11223344, 2'b10);
        mdl_store(32'h14, 32'h55667788, 2'b10);
        n_cmp++;
        if (st1 != 0 || st2 != 0) begin
            n_bad++;
            $display("FAIL b2b_store_stall: got %0d,%0d, need 0,0", st1, st2);
        end
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st1, rd, rv, mi);
        n_cmp++;
        if (rv !== 1'b1 || rd !== 32'h11223344) begin
            n_bad++;
            $display("FAIL b2b_load0: got rv=%b rdata=%h, need 1 11223344", rv, rd);
        end
        issue(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, st2, rd, rv, mi);
        n_cmp++;
        if (rv !== 1'b1 || rd !== 32'h55667788 || st2 != (Fwd ? 0 : 1)) begin
            n_bad++;
            $display("FAIL b2b_load1: got rv=%b rdata=%h stalls=%0d, need 1 55667788 %0d",
                     rv, rd, st2, Fwd ? 0 : 1);
        end
        idle();
    endtask

    task automatic test_reset_discard();
        int st;
        logic [31:0] rd;
        logic rv, mi;
        issue(1'b1, 32'h20, 32'h0, 2'b10, 1'b0, st, rd, rv, mi);
        mdl_store(32'h20, 32'h0, 2'b10);
        idle();
        issue(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, st, rd, rv, mi);
        // Store sits in the buffer; reset before it can drain.
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h20;
        req_size = 2'b10;
        #1;
        n_cmp++;
        if ({stall, rdata_valid, misalign, rdata} !== 35'h0) begin
            n_bad++;
            $display("FAIL rst_async_outputs: got stall=%b rv=%b mis=%b rdata=%h, need all 0",
                     stall, rdata_valid, misalign, rdata);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({stall, rdata_valid, misalign, rdata} !== 35'h0) begin
            n_bad++;
            $display("FAIL rst_held_outputs: got stall=%b rv=%b mis=%b rdata=%h, need all 0",
                     stall, rdata_valid, misalign, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        pend_v = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, st, rd, rv, mi);
        n_cmp++;
        if (st != 0 || rv !== 1'b1 || rd !== mdl_load(32'h20, 2'b10, 1'b0)) begin
            n_bad++;
            $display("FAIL rst_discard: got stalls=%0d rv=%b rdata=%h, need 0 1 %h",
                     st, rv, rd, mdl_load(32'h20, 2'b10, 1'b0));
        end
        idle();
    endtask

    task automatic test_wrap();
        int st;
        logic [31:0] rd;
        logic rv, mi;
        issue(1'b1, 32'h4000, 32'hCAFEF00D, 2'b10, 1'b0, st, rd, rv, mi);
        mdl_store(32'h4000, 32'hCAFEF00D, 2'b10);
        idle();
        issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, st, rd, rv, mi);
        n_cmp++;
        if (rv !== 1'b1 || rd !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL addr_wrap: got rv=%b rdata=%h, need 1 cafef00d", rv, rd);
        end
        idle();
    endtask

    task automatic test_random();
        int st, exp_st;
        logic [31:0] rd, a, d, exp_rd;
        logic rv, mi, w, u, m, conf;
        logic [1:0] sz;
        idle();
        for (int i = 0; i < 8; i++) begin
            a = 32'h300 + 32'(i * 4);
            d = $urandom;
            issue(1'b1, a, d, 2'b10, 1'b0, st, rd, rv, mi);
            mdl_store(a, d, 2'b10);
            pend_v = 1'b1;
            pend_w = word_of(a);
        end
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 5) == 0) idle();
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = 32'h300 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            a = a | (32'($urandom_range(0, 3)) << 14);
            d = $urandom;
            m = is_mis(a, sz);
            conf = !w && !m && pend_v && (pend_w == word_of(a));
            exp_st = (conf && !Fwd) ? 1 : 0;
            exp_rd = m ? 32'h0 : mdl_load(a, sz, u);
            issue(w, a, d, sz, u, st, rd, rv, mi);
            n_cmp++;
            if (st != exp_st || mi !== m || rv !== !w || (!w && rd !== exp_rd)) begin
                n_bad++;
                $display("FAIL rand[%0d] w=%b a=%h sz=%0d: got st=%0d mis=%b rv=%b rd=%h, need %0d %b %b %h",
                         i, w, a, sz, st, mi, rv, rd, exp_st, m, !w, exp_rd);
            end
            if (m) begin
                pend_v = 1'b0;
            end else if (w) begin
                mdl_store(a, d, sz);
                pend_v = 1'b1;
                pend_w = word_of(a);
            end else if (exp_st != 0) begin
                pend_v = 1'b0;
            end
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_forward();
        test_misalign();
        test_back_to_back();
        test_reset_discard();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the word count of the data array.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, meaning a memory request from the exec stage is present this cycle.
REQ-005 SHALL have port req_write, input, 1, meaning 1 = store and 0 = load.
REQ-006 SHALL have port req_addr, input, 32, the byte address (exec-stage data_addr).
REQ-007 SHALL have port req_wdata, input, 32, the store data (exec-stage data_to_memory), with bytes taken from the low lanes.
REQ-008 SHALL have port req_size, input, 2, meaning 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 SHALL have port req_unsigned, input, 1, meaning zero-extend the load (funct3[2]).
REQ-010 SHALL have port stall, output, 1, meaning the request is not accepted this cycle and the requester holds all req_* inputs.
REQ-011 SHALL have port rdata, output, 32, the extended load result.
REQ-012 SHALL have port rdata_valid, output, 1, a one-cycle pulse marking rdata.
REQ-013 SHALL have port misalign, output, 1, a one-cycle pulse flagging an accepted misaligned request.

Function
REQ-014 SHALL index the array by req_addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses wrap modulo the array size.
REQ-015 SHALL treat as misaligned: half with addr[0]=1, and word with addr[1:0]!=0.
- Misaligned request: no array or buffer change; misalign=1 and rdata=0 in the next cycle.
- On a misaligned load, rdata_valid=1 in that same cycle.
REQ-016 SHALL hold one store-buffer entry: valid, word index, 32-bit data, 4-bit byte mask.
- Data and mask are lane-shifted per addr[1:0] and size.
REQ-017 SHALL, on an accepted aligned store, write the request into the buffer in the same edge; if the buffer was valid, the old entry SHALL be written to the array in that same edge.
- Stores never stall.
REQ-018 SHALL drain a valid buffer entry to the array, using the byte mask, in any cycle with no accepted load; valid SHALL clear unless a new store is captured in that cycle.
REQ-019 SHALL accept an aligned, non-conflicting load with one-cycle latency: rdata and rdata_valid are registered and appear in the cycle after acceptance.
REQ-020 SHALL select the load byte/half by addr[1:0] and extend it per req_unsigned; a word load is passed through unchanged.
REQ-021 SHALL treat a load as conflicting when the buffer is valid and its word index equals the load's word index.
- Conflict behaviour is set by REQ-029.
REQ-022 SHALL return stall as a combinational function of the request and the buffer state only, never depending on rdata.
REQ-023 SHALL leave all outputs unchanged by req_* values when req_valid=0, except that rdata_valid and misalign drop to 0.
REQ-024 SHALL fix the read-during-write order: a load never observes an array write made in the same edge; the buffer path or the stall covers that case.

Reset
REQ-025 SHALL, while rst=1, force rdata=0, rdata_valid=0, misalign=0, stall=0, and clear buffer valid.
REQ-026 SHALL discard a buffered store that has not drained when reset asserts; array contents are not initialised by reset.
REQ-027 SHALL resume accepting requests on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL provide macro DMEM_STORE_FORWARD_EN.
REQ-029 SHALL behave as follows on a conflicting load:
- With DMEM_STORE_FORWARD_EN defined: the load is accepted with no stall; the array word is read and the buffered bytes selected by the mask are merged over it before extension; the buffer is not drained that cycle.
- Without the macro: stall=1 for exactly one cycle while the buffer drains per REQ-018; the held load is accepted in the following cycle.

Verification
REQ-030 SHALL cover: store word 0xDEADBEEF @0x100, idle cycle, load word @0x100 -> rdata=0xDEADBEEF one cycle after acceptance, stall never asserted.
REQ-031 SHALL cover: store byte 0x80 @0x203, then back-to-back load byte signed @0x203 -> rdata=0xFFFFFF80.
- With the macro: no stall.
- Without the macro: exactly one stall cycle.
REQ-032 SHALL cover: load half unsigned @0x041 -> misalign=1, rdata=0, rdata_valid=1, and the array is unchanged.
REQ-033 SHALL cover: store word 0x11223344 @0x10 followed immediately by store word 0x55667788 @0x14, then loads of both words -> 0x11223344 and 0x55667788, with no stalls on the stores.
REQ-034 SHALL cover: store @0x20, assert rst before any idle cycle, then load @0x20 -> the stored value is absent from the buffer path, and all outputs are 0 during reset.
REQ-035 SHALL cover: with DEPTH_LOG2=12, store word 0xCAFEF00D @0x4000, then load @0x0000 -> 0xCAFEF00D (address wrap).
